wb_arbiter: RTL and testbench
=============================

// Module: wb_arbiter
// PURPOSE
//  Writer side of the register-file write port: merges in-order pipeline results with results from a
//  long-latency unit (mul/div) into the single regfile write port, one write per cycle.
//  Pipeline results always win. Long-latency results wait in a DEPTH-entry FIFO and drain into idle
//  slots. Publishes busy_mask so issue logic can stall on registers that still have writes pending.
// PARAMETERS
//  DEPTH         4   long-latency FIFO entries; power of two, >=2
//  REG_LEN       32  data width (= `RegLen)
//  REG_ADDR_LEN  5   register address width (= `RegAddrLen)
// PORTS
//  clk            in   1             single clock, all state on posedge
//  rst            in   1             reset, asynchronous, active-low (0 = reset)
//  rdy            in   1             global ready; 0 freezes all state
//  pipe_valid     in   1             pipeline writeback request; no ready, always accepted
//  pipe_rd        in   REG_ADDR_LEN  pipeline destination register
//  pipe_data      in   REG_LEN       pipeline result
//  lu_valid       in   1             long-latency result offered
//  lu_ready       out  1             long-latency result accepted when lu_valid & lu_ready
//  lu_rd          in   REG_ADDR_LEN  long-latency destination register
//  lu_data        in   REG_LEN       long-latency result
//  write_enable   out  1             to regfile write port
//  write_addr     out  REG_ADDR_LEN  to regfile write port
//  write_data     out  REG_LEN       to regfile write port
//  busy_mask      out  2^REG_ADDR_LEN  bit r = 1: a FIFO entry targets register r
//  wb_pending     out  clog2(DEPTH+1)  FIFO occupancy
// BEHAVIOUR
//  - Reset (rst=0, async): FIFO flushed, rd/wr pointers and count = 0, busy_mask = 0, wb_pending = 0.
//    While rst=0: lu_ready = 0, write_enable = 0, write_addr = 0, write_data = `ZeroWord.
//    Entries in the FIFO when reset asserts are lost.
//  - rdy=0: no state changes, lu_ready = 0, write_enable = 0.
//  - Port outputs are combinational, for same-cycle forwarding in the regfile:
//    * pipe_valid & pipe_rd!=0: write port = pipe request. The FIFO does not drain.
//    * otherwise, FIFO not empty: write port = FIFO head, and the head pops at posedge.
//    * otherwise: write_enable = 0, write_addr = 0, write_data = 0.
//  - A pipe request to x0 counts as no request, so the FIFO head may use that slot.
//  - lu_ready = rdy & rst & (count < DEPTH).
//    * A full FIFO does not accept, even in a cycle where it pops.
//    * A push and a pop in the same cycle are allowed when not full; count is then unchanged.
//  - Accepted lu result with lu_rd=0: handshake completes, but nothing is stored (dropped).
//  - Min latency for lu: accepted at edge t, written to the regfile in cycle t+1 at the earliest.
//    There is no bypass from lu straight to the write port.
//  - FIFO is strict FIFO: lu results reach the regfile in acceptance order.
//  - Pointers are clog2(DEPTH) bits and wrap naturally; count saturates at DEPTH by construction.
//  - busy_mask is combinational over valid FIFO entries; bit 0 is always 0.
//  - Protocol rule: pipe_valid with pipe_rd whose busy_mask bit = 1 is illegal (a WAW hazard).
//    Issue logic must stall on busy_mask. The bench asserts on it.
// STRUCTURE
//  - Shared defines header: `RegLen, `RegAddrLen, `RegNum, `ZeroWord, `ZeroRegAddr, `Enable, `Disable.
//  - Sub-module wb_fifo: a sync FIFO of {rd, data}. It exposes per-entry valid and rd vectors so that
//    busy_mask can be built.
//  - Top level holds the priority mux and the handshake logic.
// TESTING
//  1. Reset: rst=0 with lu_valid=1 and pipe_valid=1 -> all outputs 0, lu_ready=0. Release -> lu_ready=1.
//  2. Pipe only, pipe_rd=5, data=32'hA5A5A5A5 -> write_enable=1, addr=5, data=A5A5A5A5 in the same cycle.
//  3. lu rd=7, data=1 accepted at edge t, pipe idle -> busy_mask[7]=1 and addr=7 in cycle t+1.
//     Then busy_mask[7]=0.
//  4. Push 4 lu results (rd 1..4) while the pipe writes every cycle -> lu_ready=0 after the 4th,
//     wb_pending=4. Pipe idles -> writes rd 1,2,3,4 in order.
//  5. lu_rd=0 accepted -> wb_pending stays 0 and no write occurs.
//     Also pipe_rd=0 with FIFO non-empty -> FIFO head drains that cycle.
//  6. rdy=0 for 3 cycles with 2 entries queued -> no writes, wb_pending=2.
//     rst pulse mid-drain -> wb_pending=0, busy_mask=0.

Source files
------------

// File: rtl/wb_arbiter_pkg.sv
// Shared register-file defines and the write-source encoding used by the writeback arbiter.
// The defines sit here because this file is always compiled first.
`ifndef WB_ARBITER_DEFINES
`define WB_ARBITER_DEFINES
`define RegLen      32
`define RegAddrLen  5
`define RegNum      32
`define ZeroWord    32'h0000_0000
`define ZeroRegAddr 5'h00
`define Enable      1'b1
`define Disable     1'b0
`endif

package wb_arbiter_pkg;

    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_PIPE = 2'd1,
        SRC_FIFO = 2'd2
    } wb_src_e;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of {rd, data} for long-latency results.
// Also exposes per-entry valid/rd so the top can build the busy mask.
module wb_fifo #(
    parameter int DEPTH = 4,
    parameter int DW    = 32,
    parameter int AW    = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic [AW-1:0]                push_rd,
    input  logic [DW-1:0]                push_data,
    output logic [AW-1:0]                head_rd,
    output logic [DW-1:0]                head_data,
    output logic                         full,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic [DEPTH-1:0]             entry_valid,
    output logic [AW-1:0]                entry_rd [DEPTH]
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [AW-1:0] rd_mem   [DEPTH];
    logic [DW-1:0] data_mem [DEPTH];
    logic [PW-1:0] rd_ptr_reg;
    logic [PW-1:0] wr_ptr_reg;
    logic [CW-1:0] count_reg;

    // Storage is not reset; validity comes from the pointers and count only.
    always_ff @(posedge clk) begin
        if (push) begin
            rd_mem[wr_ptr_reg]   <= push_rd;
            data_mem[wr_ptr_reg] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];
    assign full      = (count_reg == CW'(DEPTH));
    assign empty     = (count_reg == '0);
    assign count     = count_reg;

    // Slot gi holds live data when its distance from the read pointer is below the count.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
        logic [PW-1:0] offset;
        assign offset          = PW'(gi) - rd_ptr_reg;
        assign entry_valid[gi] = (CW'(offset) < count_reg);
        assign entry_rd[gi]    = rd_mem[gi];
    end

endmodule

// File: rtl/wb_arbiter.sv
// Regfile write-port arbiter: pipeline results take priority, long-latency results
// queue in a FIFO and drain into idle slots; busy_mask flags registers with pending writes.
import wb_arbiter_pkg::*;

module wb_arbiter #(
    parameter int DEPTH        = 4,
    parameter int REG_LEN      = `RegLen,
    parameter int REG_ADDR_LEN = `RegAddrLen
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rdy,
    input  logic                          pipe_valid,
    input  logic [REG_ADDR_LEN-1:0]       pipe_rd,
    input  logic [REG_LEN-1:0]            pipe_data,
    input  logic                          lu_valid,
    output logic                          lu_ready,
    input  logic [REG_ADDR_LEN-1:0]       lu_rd,
    input  logic [REG_LEN-1:0]            lu_data,
    output logic                          write_enable,
    output logic [REG_ADDR_LEN-1:0]       write_addr,
    output logic [REG_LEN-1:0]            write_data,
    output logic [(1<<REG_ADDR_LEN)-1:0]  busy_mask,
    output logic [$clog2(DEPTH+1)-1:0]    wb_pending
);
    localparam int NREG = 1 << REG_ADDR_LEN;

    logic                    active;
    logic                    pipe_hit;
    logic                    fifo_push;
    logic                    fifo_pop;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [REG_ADDR_LEN-1:0] head_rd;
    logic [REG_LEN-1:0]      head_data;
    logic [DEPTH-1:0]        entry_valid;
    logic [REG_ADDR_LEN-1:0] entry_rd [DEPTH];
    wb_src_e                 src;

    assign active    = rdy & rst;
    // A write to x0 is not a real request, so it leaves the slot free for the FIFO.
    assign pipe_hit  = pipe_valid & (pipe_rd != '0);
    assign lu_ready  = active & ~fifo_full;
    assign fifo_push = lu_valid & lu_ready & (lu_rd != '0);
    assign fifo_pop  = (src == SRC_FIFO);

    wb_fifo #(
        .DEPTH (DEPTH),
        .DW    (REG_LEN),
        .AW    (REG_ADDR_LEN)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push        (fifo_push),
        .pop         (fifo_pop),
        .push_rd     (lu_rd),
        .push_data   (lu_data),
        .head_rd     (head_rd),
        .head_data   (head_data),
        .full        (fifo_full),
        .empty       (fifo_empty),
        .count       (wb_pending),
        .entry_valid (entry_valid),
        .entry_rd    (entry_rd)
    );

    always_comb begin
        src          = SRC_NONE;
        write_enable = `Disable;
        write_addr   = '0;
        write_data   = '0;
        if (active) begin
            if (pipe_hit)         src = SRC_PIPE;
            else if (!fifo_empty) src = SRC_FIFO;
        end
        case (src)
            SRC_PIPE: begin
                write_enable = `Enable;
                write_addr   = pipe_rd;
                write_data   = pipe_data;
            end
            SRC_FIFO: begin
                write_enable = `Enable;
                write_addr   = head_rd;
                write_data   = head_data;
            end
            default: ;
        endcase
    end

    for (genvar gi = 0; gi < NREG; gi++) begin : g_busy
        if (gi == 0) begin : g_zero
            assign busy_mask[gi] = 1'b0;
        end else begin : g_reg
            logic [DEPTH-1:0] hit;
            for (genvar gj = 0; gj < DEPTH; gj++) begin : g_hit
                assign hit[gj] = entry_valid[gj] & (entry_rd[gj] == REG_ADDR_LEN'(gi));
            end
            assign busy_mask[gi] = |hit;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        pipe_valid;
    logic [4:0]  pipe_rd;
    logic [31:0] pipe_data;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        write_enable;
    logic [4:0]  write_addr;
    logic [31:0] write_data;
    logic [31:0] busy_mask;
    logic [2:0]  wb_pending;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wr_t;

    wr_t pipe_q[$];
    wr_t lu_q[$];
    int  checks = 0;
    int  errors = 0;

    wb_arbiter #(.DEPTH(4), .REG_LEN(32), .REG_ADDR_LEN(5)) dut (
        .clk          (clk),
        .rst          (rst),
        .rdy          (rdy),
        .pipe_valid   (pipe_valid),
        .pipe_rd      (pipe_rd),
        .pipe_data    (pipe_data),
        .lu_valid     (lu_valid),
        .lu_ready     (lu_ready),
        .lu_rd        (lu_rd),
        .lu_data      (lu_data),
        .write_enable (write_enable),
        .write_addr   (write_addr),
        .write_data   (write_data),
        .busy_mask    (busy_mask),
        .wb_pending   (wb_pending)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [36:0] act, input logic [36:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic lu_offer(input logic [4:0] rd, input logic [31:0] data);
        lu_valid = 1'b1;
        lu_rd    = rd;
        lu_data  = data;
        #1;
        chk("lu_ready_offer", 37'(lu_ready), 37'd1);
        if (rd != 5'd0) lu_q.push_back('{rd: rd, data: data});
    endtask

    task automatic pipe_drive(input logic [4:0] rd, input logic [31:0] data);
        pipe_valid = 1'b1;
        pipe_rd    = rd;
        pipe_data  = data;
        if (rd != 5'd0) pipe_q.push_back('{rd: rd, data: data});
    endtask

    // Monitor: every write the DUT presents is matched against the source-appropriate queue.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst && rdy && pipe_valid && pipe_rd != 5'd0)
                assert (!busy_mask[pipe_rd]) else $error("WAW hazard driven on x%0d", pipe_rd);
            if (write_enable) begin
                if (rst && rdy && pipe_valid && pipe_rd != 5'd0) begin
                    checks++;
                    if (pipe_q.size() == 0) begin
                        errors++;
                        $display("FAIL pipe_write: got rd=%0d data=%0h, expected none", write_addr, write_data);
                    end else begin
                        e = pipe_q.pop_front();
                        if ({write_addr, write_data} !== {e.rd, e.data}) begin
                            errors++;
                            $display("FAIL pipe_write: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                                     write_addr, write_data, e.rd, e.data);
                        end else $display("ok   pipe_write rd=%0d data=%0h", write_addr, write_data);
                    end
                end else begin
                    checks++;
                    if (lu_q.size() == 0) begin
                        errors++;
                        $display("FAIL lu_write: got rd=%0d data=%0h, expected none", write_addr, write_data);
                    end else begin
                        e = lu_q.pop_front();
                        if ({write_addr, write_data} !== {e.rd, e.data}) begin
                            errors++;
                            $display("FAIL lu_write: got rd=%0d data=%0h, expected rd=%0d data=%0h",
                                     write_addr, write_data, e.rd, e.data);
                        end else $display("ok   lu_write rd=%0d data=%0h", write_addr, write_data);
                    end
                end
            end else if (rst && rdy && pipe_valid && pipe_rd != 5'd0) begin
                checks++;
                errors++;
                $display("FAIL pipe_write: got no write, expected rd=%0d data=%0h", pipe_rd, pipe_data);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        // 1. Reset with requests present
        rst = 1'b0; rdy = 1'b1;
        pipe_valid = 1'b1; pipe_rd = 5'd5; pipe_data = 32'h1234_5678;
        lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h9;
        step(); step();
        chk("rst_write_enable", 37'(write_enable), 37'd0);
        chk("rst_write_addr",   37'(write_addr),   37'd0);
        chk("rst_write_data",   37'(write_data),   37'd0);
        chk("rst_lu_ready",     37'(lu_ready),     37'd0);
        chk("rst_wb_pending",   37'(wb_pending),   37'd0);
        chk("rst_busy_mask",    37'(busy_mask),    37'd0);
        pipe_valid = 1'b0; lu_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("post_rst_lu_ready", 37'(lu_ready), 37'd1);
        step();

        // 2. Pipe-only write, same-cycle
        pipe_drive(5'd5, 32'hA5A5_A5A5);
        #1;
        chk("pipe_we",   37'(write_enable), 37'd1);
        chk("pipe_addr", 37'(write_addr),   37'd5);
        chk("pipe_data", 37'(write_data),   37'hA5A5_A5A5);
        step();
        pipe_valid = 1'b0;

        // 3. Single lu result, minimum latency, no bypass
        lu_offer(5'd7, 32'h1);
        chk("lu_no_bypass", 37'(write_enable), 37'd0);
        step();
        lu_valid = 1'b0;
        #1;
        chk("lu_busy7",    37'(busy_mask[7]), 37'd1);
        chk("lu_addr7",    37'(write_addr),   37'd7);
        chk("lu_pending1", 37'(wb_pending),   37'd1);
        step();
        chk("lu_busy7_clear", 37'(busy_mask[7]), 37'd0);
        chk("lu_pending0",    37'(wb_pending),   37'd0);

        // 4. Fill FIFO while the pipe holds the port, then drain in order
        for (int i = 1; i <= 4; i++) begin
            pipe_drive(5'(10 + i), 32'hB000_0000 + 32'(i));
            lu_offer(5'(i), 32'h100 + 32'(i));
            step();
        end
        pipe_drive(5'd20, 32'hC0DE_0020);
        lu_valid = 1'b1; lu_rd = 5'd9; lu_data = 32'hDEAD;
        #1;
        chk("full_lu_ready", 37'(lu_ready),       37'd0);
        chk("full_pending",  37'(wb_pending),     37'd4);
        chk("full_busy",     37'(busy_mask[4:0]), 37'h1E);
        step();
        pipe_valid = 1'b0; lu_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            #1;
            chk("drain_addr",    37'(write_addr), 37'(k));
            chk("drain_pending", 37'(wb_pending), 37'(5 - k));
            step();
        end

        // 5. lu to x0 dropped; pipe to x0 lets FIFO drain
        lu_offer(5'd0, 32'hDEAD_BEEF);
        step();
        lu_valid = 1'b0;
        #1;
        chk("x0_pending", 37'(wb_pending),   37'd0);
        chk("x0_no_write", 37'(write_enable), 37'd0);
        pipe_drive(5'd15, 32'h0000_0F0F);
        lu_offer(5'd6, 32'h66);
        step();
        lu_valid = 1'b0;
        pipe_drive(5'd0, 32'hFFFF_FFFF);
        #1;
        chk("pipe_x0_drain_we",   37'(write_enable), 37'd1);
        chk("pipe_x0_drain_addr", 37'(write_addr),   37'd6);
        step();
        pipe_valid = 1'b0;
        chk("pipe_x0_pending", 37'(wb_pending), 37'd0);

        // 6. rdy freeze, then reset mid-drain
        pipe_drive(5'd15, 32'h15);
        lu_offer(5'd8, 32'h88);
        step();
        pipe_drive(5'd16, 32'h16);
        lu_offer(5'd9, 32'h99);
        step();
        pipe_valid = 1'b0; lu_valid = 1'b0;
        rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1;
            chk("frz_we",       37'(write_enable), 37'd0);
            chk("frz_lu_ready", 37'(lu_ready),     37'd0);
            chk("frz_pending",  37'(wb_pending),   37'd2);
            step();
        end
        rdy = 1'b1;
        #1;
        chk("resume_addr", 37'(write_addr), 37'd8);
        step();
        rst = 1'b0;
        lu_q.delete();
        #1;
        chk("midrst_pending", 37'(wb_pending), 37'd0);
        chk("midrst_busy",    37'(busy_mask),  37'd0);
        step();
        rst = 1'b1;
        step(); step();
        chk("end_pipe_q", 37'(pipe_q.size()), 37'd0);
        chk("end_lu_q",   37'(lu_q.size()),   37'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
